// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package fetch_pkg;

    localparam int FQ_XLEN = 32;
    localparam int FQ_ILEN = 32;

    localparam logic [FQ_XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int                 DEF_PC_STEP  = 4;

    typedef struct packed {
        logic               filled;
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_ILEN-1:0] inst;
    } fq_entry_t;

    // Circular-buffer pointer advance; depth need not be a power of two here.
    function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input int unsigned depth);
        return (ptr + 32'd1) % depth;
    endfunction

endpackage

// File: rtl/fq_storage.sv
// Prefetch queue slot array: reserve writes the PC, fill writes the instruction,
// retire frees the head slot, flush empties every slot.
module fq_storage
    import fetch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            reserve_en,
    input  logic [PW-1:0]   reserve_ptr,
    input  logic [XLEN-1:0] reserve_pc,
    input  logic            fill_en,
    input  logic [PW-1:0]   fill_ptr,
    input  logic [ILEN-1:0] fill_inst,
    input  logic            retire_en,
    input  logic [PW-1:0]   retire_ptr,
    input  logic [PW-1:0]   head_ptr,
    output logic            head_filled,
    output logic [XLEN-1:0] head_pc,
    output logic [ILEN-1:0] head_inst
);

    logic            filled_all [DEPTH];
    logic [XLEN-1:0] pc_all     [DEPTH];
    logic [ILEN-1:0] inst_all   [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic            filled_reg;
            logic [XLEN-1:0] pc_reg;
            logic [ILEN-1:0] inst_reg;

            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    filled_reg <= 1'b0;
                    pc_reg     <= '0;
                    inst_reg   <= '0;
                end else begin
                    // A slot is never filled and retired together: fill needs it unfilled.
                    if (fill_en && fill_ptr == PW'(gi)) begin
                        filled_reg <= 1'b1;
                        inst_reg   <= fill_inst;
                    end else if (retire_en && retire_ptr == PW'(gi)) begin
                        filled_reg <= 1'b0;
                    end
                    if (reserve_en && reserve_ptr == PW'(gi)) begin
                        pc_reg <= reserve_pc;
                    end
                end
            end

            assign filled_all[gi] = filled_reg;
            assign pc_all[gi]     = pc_reg;
            assign inst_all[gi]   = inst_reg;
        end
    endgenerate

    assign head_filled = filled_all[head_ptr];
    assign head_pc     = pc_all[head_ptr];
    assign head_inst   = inst_all[head_ptr];

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front end: PC generator, pipelined imem request/response and prefetch queue.
// Optional macro FETCH_PERF_CNT_EN adds saturating request/redirect/stall counters.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
    parameter int              PC_STEP  = DEF_PC_STEP
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_en,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [ILEN-1:0]            imem_rsp_data,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [ILEN-1:0]            deq_inst,
    output logic [XLEN-1:0]            deq_pc,
    output logic [XLEN-1:0]            deq_pc4,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                perf_req_cnt,
    output logic [31:0]                perf_redirect_cnt,
    output logic [31:0]                perf_stall_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);
    // Drops can pile up across back-to-back redirects, so leave generous headroom.
    localparam int DW = 16;

    logic [XLEN-1:0] fetch_pc_reg;
    logic [PW-1:0]   issue_ptr_reg;
    logic [PW-1:0]   rsp_ptr_reg;
    logic [PW-1:0]   head_ptr_reg;
    logic [OW-1:0]   occ_reg;
    logic [OW-1:0]   inflight_reg;
    logic [DW-1:0]   drop_cnt_reg;

    logic            req_fire;
    logic            rsp_drop;
    logic            rsp_fill;
    logic            deq_fire;
    logic            head_filled;
    logic [XLEN-1:0] head_pc;
    logic [ILEN-1:0] head_inst;

    assign imem_req_valid = fetch_en & ~reset & ~redirect_valid & (occ_reg < OW'(DEPTH));
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign rsp_drop = imem_rsp_valid & (drop_cnt_reg != '0);
    assign rsp_fill = imem_rsp_valid & (drop_cnt_reg == '0) & ~redirect_valid;

    assign deq_valid = head_filled & ~redirect_valid;
    assign deq_fire  = deq_valid & deq_ready;
    assign deq_inst  = head_inst;
    assign deq_pc    = head_pc;
    assign deq_pc4   = head_pc + XLEN'(PC_STEP);
    assign occupancy = occ_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_reg  <= RESET_PC;
            issue_ptr_reg <= '0;
            rsp_ptr_reg   <= '0;
            head_ptr_reg  <= '0;
            occ_reg       <= '0;
            inflight_reg  <= '0;
            drop_cnt_reg  <= '0;
        end else if (redirect_valid) begin
            fetch_pc_reg  <= redirect_pc;
            issue_ptr_reg <= '0;
            rsp_ptr_reg   <= '0;
            head_ptr_reg  <= '0;
            occ_reg       <= '0;
            inflight_reg  <= '0;
            // Any response arriving now, dropped or not, is one fewer to discard later.
            drop_cnt_reg  <= drop_cnt_reg + DW'(inflight_reg) - DW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_reg  <= fetch_pc_reg + XLEN'(PC_STEP);
                issue_ptr_reg <= PW'(next_ptr(32'(issue_ptr_reg), DEPTH));
            end
            if (rsp_drop) begin
                drop_cnt_reg <= drop_cnt_reg - DW'(1);
            end
            if (rsp_fill) begin
                rsp_ptr_reg <= PW'(next_ptr(32'(rsp_ptr_reg), DEPTH));
            end
            if (deq_fire) begin
                head_ptr_reg <= PW'(next_ptr(32'(head_ptr_reg), DEPTH));
            end
            occ_reg      <= occ_reg + OW'(req_fire) - OW'(deq_fire);
            inflight_reg <= inflight_reg + OW'(req_fire) - OW'(rsp_fill);
        end
    end

    fq_storage #(
        .XLEN  (XLEN),
        .ILEN  (ILEN),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_storage (
        .clk         (clk),
        .reset       (reset),
        .flush       (redirect_valid),
        .reserve_en  (req_fire),
        .reserve_ptr (issue_ptr_reg),
        .reserve_pc  (fetch_pc_reg),
        .fill_en     (rsp_fill),
        .fill_ptr    (rsp_ptr_reg),
        .fill_inst   (imem_rsp_data),
        .retire_en   (deq_fire),
        .retire_ptr  (head_ptr_reg),
        .head_ptr    (head_ptr_reg),
        .head_filled (head_filled),
        .head_pc     (head_pc),
        .head_inst   (head_inst)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_req_reg;
    logic [31:0] perf_redirect_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_req_reg      <= '0;
            perf_redirect_reg <= '0;
            perf_stall_reg    <= '0;
        end else begin
            if (req_fire && perf_req_reg != '1) begin
                perf_req_reg <= perf_req_reg + 32'd1;
            end
            if (redirect_valid && perf_redirect_reg != '1) begin
                perf_redirect_reg <= perf_redirect_reg + 32'd1;
            end
            if (deq_valid && !deq_ready && perf_stall_reg != '1) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_req_cnt      = perf_req_reg;
    assign perf_redirect_cnt = perf_redirect_reg;
    assign perf_stall_cnt    = perf_stall_reg;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: vector table plus a scoreboarded memory model.
module tb_fetch_queue_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_en = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        deq_valid;
    logic        deq_ready = 1'b0;
    logic [31:0] deq_inst;
    logic [31:0] deq_pc;
    logic [31:0] deq_pc4;
    logic [2:0]  occupancy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_req_cnt, perf_redirect_cnt, perf_stall_cnt;
`endif

    fetch_queue_unit dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_inst       (deq_inst),
        .deq_pc         (deq_pc),
        .deq_pc4        (deq_pc4),
        .occupancy      (occupancy)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_req_cnt      (perf_req_cnt),
        .perf_redirect_cnt (perf_redirect_cnt),
        .perf_stall_cnt    (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic        fe;
        logic        dr;
        logic        rv;
        logic [31:0] addr;
        logic        dv;
        logic [31:0] dpc;
        int          occ;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 1;
    mreq_t       mq[$];
    fq_entry_t   exp_q[$];
    logic [31:0] m_pc = 32'h0;
    int          m_occ = 0;
    vec_t        tbl[16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h cycle=%0d", name, got, want, cyc);
        end
    endtask

    // One clock: check against the reference model, cross the edge, then update
    // the model and the pipelined memory (fixed latency, in-order, returns addr>>2).
    task automatic tick();
        logic        m_rv, m_fire, d_fire, d_deq, s_reset, s_redir, s_rspv;
        logic [31:0] s_addr, s_rpc;
        fq_entry_t   e;
        #1;
        s_reset = reset;
        s_redir = redirect_valid;
        s_rpc   = redirect_pc;
        s_rspv  = imem_rsp_valid;
        s_addr  = imem_req_addr;
        m_rv    = fetch_en && !reset && !redirect_valid && (m_occ < DEPTH);
        m_fire  = m_rv && imem_req_ready;
        d_fire  = imem_req_valid && imem_req_ready;
        d_deq   = deq_valid && deq_ready;
        if (!reset) begin
            chk("req_valid", 32'(imem_req_valid), 32'(m_rv));
            if (m_rv) chk("req_addr", imem_req_addr, m_pc);
            chk("occupancy", 32'(occupancy), 32'(m_occ));
            if (redirect_valid) chk("deq_valid_in_redirect", 32'(deq_valid), 32'(0));
            if (d_deq) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL deq_unexpected: got pc=%h want=none cycle=%0d", deq_pc, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("deq_pc", deq_pc, e.pc);
                    chk("deq_inst", deq_inst, e.inst);
                    chk("deq_pc4", deq_pc4, e.pc + 32'd4);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (s_reset) begin
            mq.delete();
            exp_q.delete();
            m_pc  = DEF_RESET_PC;
            m_occ = 0;
        end else begin
            if (s_rspv && mq.size() > 0) void'(mq.pop_front());
            if (d_fire) mq.push_back('{s_addr, cyc + lat - 1});
            if (s_redir) begin
                m_pc  = s_rpc;
                m_occ = 0;
                exp_q.delete();
            end else begin
                if (m_fire) begin
                    exp_q.push_back('{1'b1, m_pc, m_pc >> 2});
                    m_pc = m_pc + 32'd4;
                    m_occ++;
                end
                if (d_deq) m_occ--;
            end
        end
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq[0].addr >> 2;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        fetch_en       = 1'b0;
        deq_ready      = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        #1;
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'(0));
        chk({tag, "_req_addr"}, imem_req_addr, DEF_RESET_PC);
        chk({tag, "_deq_valid"}, 32'(deq_valid), 32'(0));
        chk({tag, "_occupancy"}, 32'(occupancy), 32'(0));
        chk({tag, "_deq_pc"}, deq_pc, 32'(0));
        chk({tag, "_deq_inst"}, deq_inst, 32'(0));
    endtask

    task automatic wait_first_deq(input string tag, input logic [31:0] want_pc);
        for (int i = 0; i < 30 && !deq_valid; i++) tick();
        #1;
        if (!deq_valid) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got deq_valid=0 want=1 cycle=%0d", tag, cyc);
        end else begin
            chk(tag, deq_pc, want_pc);
        end
    endtask

    function automatic vec_t mk(input logic fe, input logic dr, input logic rv, input logic [31:0] addr,
                                input logic dv, input logic [31:0] dpc, input int occ);
        vec_t v;
        v.fe = fe; v.dr = dr; v.rv = rv; v.addr = addr; v.dv = dv; v.dpc = dpc; v.occ = occ;
        return v;
    endfunction

    initial begin
        bit seen_wrap;
        // Decode stall from reset with 1-cycle memory, then release.
        tbl[0]  = mk(1, 0, 1, 32'h00, 0, 32'h00, 0);
        tbl[1]  = mk(1, 0, 1, 32'h04, 0, 32'h00, 1);
        tbl[2]  = mk(1, 0, 1, 32'h08, 1, 32'h00, 2);
        tbl[3]  = mk(1, 0, 1, 32'h0C, 1, 32'h00, 3);
        tbl[4]  = mk(1, 0, 0, 32'h10, 1, 32'h00, 4);
        tbl[5]  = mk(1, 0, 0, 32'h10, 1, 32'h00, 4);
        tbl[6]  = mk(1, 0, 0, 32'h10, 1, 32'h00, 4);
        tbl[7]  = mk(1, 0, 0, 32'h10, 1, 32'h00, 4);
        tbl[8]  = mk(1, 0, 0, 32'h10, 1, 32'h00, 4);
        tbl[9]  = mk(1, 0, 0, 32'h10, 1, 32'h00, 4);
        tbl[10] = mk(1, 1, 0, 32'h10, 1, 32'h00, 4);
        tbl[11] = mk(1, 1, 1, 32'h10, 1, 32'h04, 3);
        tbl[12] = mk(1, 1, 1, 32'h14, 1, 32'h08, 3);
        tbl[13] = mk(1, 1, 1, 32'h18, 1, 32'h0C, 3);
        tbl[14] = mk(1, 1, 1, 32'h1C, 1, 32'h10, 3);
        tbl[15] = mk(1, 1, 1, 32'h20, 1, 32'h14, 3);

        lat = 1;
        do_reset();
        check_zero("reset");
        for (int i = 0; i < 16; i++) begin
            fetch_en  = tbl[i].fe;
            deq_ready = tbl[i].dr;
            #1;
            chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].rv));
            chk($sformatf("vec%0d_req_addr", i), imem_req_addr, tbl[i].addr);
            chk($sformatf("vec%0d_deq_valid", i), 32'(deq_valid), 32'(tbl[i].dv));
            chk($sformatf("vec%0d_occupancy", i), 32'(occupancy), 32'(tbl[i].occ));
            if (tbl[i].dv) begin
                chk($sformatf("vec%0d_deq_pc", i), deq_pc, tbl[i].dpc);
                chk($sformatf("vec%0d_deq_inst", i), deq_inst, tbl[i].dpc >> 2);
            end
            tick();
        end
        for (int i = 0; i < 6; i++) tick();

        // Redirect with three requests in flight on a 3-cycle memory.
        lat = 3;
        do_reset();
        fetch_en  = 1'b1;
        deq_ready = 1'b1;
        tick();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        chk("inflight_before_redirect", 32'(occupancy), 32'(3));
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("post_redirect_req_valid", 32'(imem_req_valid), 32'(1));
        chk("post_redirect_req_addr", imem_req_addr, 32'h100);
        wait_first_deq("first_deq_after_redirect", 32'h100);
        for (int i = 0; i < 4; i++) tick();

        // Back-to-back redirects: only the second stream reaches decode.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_pc    = 32'h80;
        tick();
        redirect_valid = 1'b0;
        wait_first_deq("first_deq_after_double_redirect", 32'h80);
        for (int i = 0; i < 4; i++) tick();

        // Address wrap at the top of the space, with memory backpressure.
        lat = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        seen_wrap = 1'b0;
        for (int i = 0; i < 30; i++) begin
            imem_req_ready = (i % 3 != 0);
            #1;
            if (deq_valid && deq_pc == 32'hFFFF_FFFC && !seen_wrap) begin
                seen_wrap = 1'b1;
                chk("wrap_deq_pc4", deq_pc4, 32'h0000_0000);
            end
            tick();
        end
        imem_req_ready = 1'b1;
        if (!seen_wrap) begin
            total++;
            bad++;
            $display("FAIL wrap_deq_missing: got none want deq_pc=fffffffc cycle=%0d", cyc);
        end

        // Reset with a full queue and two responses still in flight.
        lat = 3;
        do_reset();
        fetch_en  = 1'b1;
        deq_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #1;
        chk("full_occupancy", 32'(occupancy), 32'(4));
        chk("full_req_valid", 32'(imem_req_valid), 32'(0));
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        fetch_en = 1'b0;
        check_zero("midreset");
        lat       = 1;
        fetch_en  = 1'b1;
        deq_ready = 1'b1;
        wait_first_deq("first_deq_after_midreset", DEF_RESET_PC);
        for (int i = 0; i < 6; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
